// File: rtl/huffman_grp_detect.sv
// Huffman group detector: per-code-width lookup table mapping a C_W-bit code to its decoded symbol.
// Latency: lookup is combinational (zero cycles); table writes/clears are visible the cycle after the edge.
// Backpressure: none; every cycle is a lookup cycle and configuration may run concurrently.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   rst          - asynchronous active-low reset, clears every entry and symbol
//   d_conf       - symbol to store on a configuration write
//   h_conf       - right-aligned Huffman code used as the table index
//   w_conf       - code width of the configuration word; only C_W writes land here
//   en_conf      - configuration write strobe
//   new_conf     - synchronous clear of all valid flags, wins over a simultaneous write
//   d2check      - candidate code to look up
//   code_matched - d2check addresses a valid entry
//   data_encoded - stored symbol for d2check, zero when not matched
module huffman_grp_detect #(
  parameter int NUM_OF_CHARS = 4,
  parameter int D_W          = 8,
  parameter int C_W          = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D_W-1:0] d_conf,
  input  logic [D_W-1:0] h_conf,
  input  logic [D_W-1:0] w_conf,
  input  logic           en_conf,
  input  logic           new_conf,
  input  logic [C_W-1:0] d2check,
  output logic           code_matched,
  output logic [D_W-1:0] data_encoded
);

  logic [D_W-1:0]          sym [NUM_OF_CHARS];
  logic [NUM_OF_CHARS-1:0] valid;
  logic                    wr;

  // Full-width compares: a wider group's code whose low bits alias an index here
  // must not land in this table, and neither may an out-of-range index.
  assign wr = en_conf && !new_conf
           && (w_conf == D_W'(C_W))
           && (h_conf < D_W'(NUM_OF_CHARS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < NUM_OF_CHARS; i++) begin
        sym[i] <= '0;
      end
    end else if (new_conf) begin
      valid <= '0;
    end else if (wr) begin
      for (int i = 0; i < NUM_OF_CHARS; i++) begin
        if (h_conf == D_W'(i)) begin
          sym[i]   <= d_conf;
          valid[i] <= 1'b1;
        end
      end
    end
  end

  // Codes at or above NUM_OF_CHARS never match any entry, so they fall out as zero.
  always_comb begin
    code_matched = 1'b0;
    data_encoded = '0;
    for (int i = 0; i < NUM_OF_CHARS; i++) begin
      if ((d2check == C_W'(i)) && valid[i]) begin
        code_matched = 1'b1;
        data_encoded = sym[i];
      end
    end
  end

endmodule

// File: tb/tb_huffman_grp_detect.sv
module tb_huffman_grp_detect;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] d_conf, h_conf, w_conf;
  logic          en_conf, new_conf;
  logic [CW-1:0] d2check;
  logic          code_matched;
  logic [DW-1:0] data_encoded;

  int checks = 0;
  int errors = 0;

  // Reference table: what a decoder configured by the writes so far should hold.
  bit            mvalid [N];
  logic [DW-1:0] msym   [N];

  huffman_grp_detect #(.NUM_OF_CHARS(N), .D_W(DW), .C_W(CW)) dut (
    .clk(clk), .rst(rst), .d_conf(d_conf), .h_conf(h_conf), .w_conf(w_conf),
    .en_conf(en_conf), .new_conf(new_conf), .d2check(d2check),
    .code_matched(code_matched), .data_encoded(data_encoded)
  );

  always #5 clk = ~clk;

  function automatic bit exp_match(int code);
    if (code >= N) return 1'b0;
    return mvalid[code];
  endfunction

  function automatic logic [DW-1:0] exp_data(int code);
    if (!exp_match(code)) return '0;
    return msym[code];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mvalid[i] = 1'b0;
      msym[i]   = '0;
    end
  endtask

  // Apply the configuration rules to the reference for the coming edge.
  task automatic model_edge();
    if (new_conf) begin
      for (int i = 0; i < N; i++) mvalid[i] = 1'b0;
    end else if (en_conf && int'(w_conf) == CW && int'(h_conf) < N) begin
      msym[int'(h_conf)]   = d_conf;
      mvalid[int'(h_conf)] = 1'b1;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_conf  = 1'b0;
    new_conf = 1'b0;
    d_conf   = '0;
    h_conf   = '0;
    w_conf   = '0;
  endtask

  task automatic do_write(input logic [DW-1:0] h, input logic [DW-1:0] d, input logic [DW-1:0] w);
    en_conf = 1'b1;
    new_conf = 1'b0;
    h_conf = h;
    d_conf = d;
    w_conf = w;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    d2check = '0;
    model_clear();
    #1;
    if (code_matched !== 1'b0 || data_encoded !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: matched=%b data=%h required 0/00", code_matched, data_encoded);
    end
    checks++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < (1 << CW); c++) begin
      d2check = CW'(c);
      #1;
      if (code_matched !== 1'b0 || data_encoded !== 8'h00) begin
        errors++;
        $display("FAIL reset_sweep code=%0d: matched=%b data=%h required 0/00", c, code_matched, data_encoded);
      end
      checks++;
    end
  endtask

  task automatic test_basic_write();
    do_write(8'd2, 8'hA5, 8'd2);
    d2check = 2'd2;
    #1;
    if (code_matched !== 1'b1 || data_encoded !== 8'hA5) begin
      errors++;
      $display("FAIL basic_write hit: matched=%b data=%h required 1/a5", code_matched, data_encoded);
    end
    checks++;
    d2check = 2'd1;
    #1;
    if (code_matched !== 1'b0 || data_encoded !== 8'h00) begin
      errors++;
      $display("FAIL basic_write miss: matched=%b data=%h required 0/00", code_matched, data_encoded);
    end
    checks++;
  endtask

  task automatic test_width_filter();
    do_write(8'd1, 8'h33, 8'd3);
    do_write(8'd1, 8'h44, 8'h82);  // low bits alias width 2
    d2check = 2'd1;
    #1;
    if (code_matched !== 1'b0 || data_encoded !== 8'h00) begin
      errors++;
      $display("FAIL width_filter: matched=%b data=%h required 0/00", code_matched, data_encoded);
    end
    checks++;
  endtask

  task automatic test_out_of_range();
    do_write(8'd6, 8'h55, 8'd2);   // aliases index 2
    do_write(8'd4, 8'h66, 8'd2);   // aliases index 0
    d2check = 2'd2;
    #1;
    if (code_matched !== 1'b1 || data_encoded !== 8'hA5) begin
      errors++;
      $display("FAIL out_of_range idx2: matched=%b data=%h required 1/a5", code_matched, data_encoded);
    end
    checks++;
    d2check = 2'd0;
    #1;
    if (code_matched !== 1'b0 || data_encoded !== 8'h00) begin
      errors++;
      $display("FAIL out_of_range idx0: matched=%b data=%h required 0/00", code_matched, data_encoded);
    end
    checks++;
  endtask

  task automatic test_clear();
    for (int i = 0; i < N; i++) do_write(DW'(i), 8'h10 + DW'(i), 8'd2);
    for (int i = 0; i < N; i++) begin
      d2check = CW'(i);
      #1;
      if (code_matched !== 1'b1 || data_encoded !== (8'h10 + DW'(i))) begin
        errors++;
        $display("FAIL fill idx=%0d: matched=%b data=%h required 1/%h", i, code_matched, data_encoded, 8'h10 + DW'(i));
      end
      checks++;
    end
    en_conf = 1'b1; new_conf = 1'b1; w_conf = 8'd2; h_conf = 8'd1; d_conf = 8'h99;
    cycle();
    idle();
    for (int i = 0; i < N; i++) begin
      d2check = CW'(i);
      #1;
      if (code_matched !== 1'b0 || data_encoded !== 8'h00) begin
        errors++;
        $display("FAIL clear idx=%0d: matched=%b data=%h required 0/00", i, code_matched, data_encoded);
      end
      checks++;
    end
  endtask

  task automatic test_overwrite_async_reset();
    do_write(8'd3, 8'h7E, 8'd2);
    d2check = 2'd3;
    #1;
    if (code_matched !== 1'b1 || data_encoded !== 8'h7E) begin
      errors++;
      $display("FAIL overwrite first: matched=%b data=%h required 1/7e", code_matched, data_encoded);
    end
    checks++;
    do_write(8'd3, 8'h81, 8'd2);
    #1;
    if (code_matched !== 1'b1 || data_encoded !== 8'h81) begin
      errors++;
      $display("FAIL overwrite second: matched=%b data=%h required 1/81", code_matched, data_encoded);
    end
    checks++;
    // Start a write, then pull reset mid-cycle; outputs must drop before any edge.
    en_conf = 1'b1; w_conf = 8'd2; h_conf = 8'd0; d_conf = 8'h5A;
    #2;
    rst = 1'b0;
    #1;
    if (code_matched !== 1'b0 || data_encoded !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: matched=%b data=%h required 0/00", code_matched, data_encoded);
    end
    checks++;
    model_clear();
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      d2check = CW'(i);
      #1;
      if (code_matched !== 1'b0 || data_encoded !== 8'h00) begin
        errors++;
        $display("FAIL reset_discard idx=%0d: matched=%b data=%h required 0/00", i, code_matched, data_encoded);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en_conf  = ($urandom_range(0, 3) != 0);
      new_conf = ($urandom_range(0, 19) == 0);
      w_conf   = ($urandom_range(0, 3) != 0) ? 8'd2 : DW'($urandom_range(0, 255));
      h_conf   = ($urandom_range(0, 4) != 0) ? DW'($urandom_range(0, 5)) : DW'($urandom_range(0, 255));
      d_conf   = DW'($urandom_range(0, 255));
      d2check  = CW'($urandom_range(0, 3));
      #1;
      // Compared before the edge: pending write data must not be forwarded.
      if (code_matched !== exp_match(int'(d2check)) || data_encoded !== exp_data(int'(d2check))) begin
        errors++;
        $display("FAIL random n=%0d code=%0d: matched=%b data=%h required %b/%h",
                 n, d2check, code_matched, data_encoded, exp_match(int'(d2check)), exp_data(int'(d2check)));
      end
      checks++;
      cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_width_filter();
    test_out_of_range();
    test_clear();
    test_overwrite_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
